// File: rtl/ram_nport_arb.sv
// NUM_PORTS requestors share one single-port MEMORY_DEPTH x DATA_WIDTH core, one access per cycle.
// Define RAM_NPORT_RR_ARB_EN for round-robin arbitration; otherwise fixed priority (port 0 highest).
module ram_nport_arb #(
    parameter int NUM_PORTS     = 4,
    parameter int MEMORY_DEPTH  = 1024,
    parameter int ADDRESS_WIDTH = $clog2(MEMORY_DEPTH),
    parameter int DATA_WIDTH    = 32
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [NUM_PORTS-1:0]               port_en,
    input  logic [NUM_PORTS-1:0]               port_we,
    input  logic [NUM_PORTS*ADDRESS_WIDTH-1:0] port_addr,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]    port_write_data,
    output logic [NUM_PORTS*DATA_WIDTH-1:0]    port_read_data,
    output logic [NUM_PORTS-1:0]               port_done
);
    localparam int IDX_W = $clog2(NUM_PORTS);

    logic [DATA_WIDTH-1:0]    mem [MEMORY_DEPTH];
    logic [NUM_PORTS-1:0]     eligible;
    logic                     vld_p0;
    logic [IDX_W-1:0]         gnt_idx_p0;
    logic                     we_p0;
    logic [ADDRESS_WIDTH-1:0] addr_p0;
    logic [DATA_WIDTH-1:0]    wdata_p0;
    logic                     in_range_p0;

    // A port whose done pulse is showing sits out this cycle, so a held port_en re-requests a cycle later.
    assign eligible = port_en & ~port_done;

`ifdef RAM_NPORT_RR_ARB_EN
    localparam logic [IDX_W:0]   NP_L   = (IDX_W+1)'(NUM_PORTS);
    localparam logic [IDX_W-1:0] LAST_L = IDX_W'(NUM_PORTS-1);

    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W:0]   rr_sum;

    always_comb begin
        vld_p0     = 1'b0;
        gnt_idx_p0 = '0;
        rr_sum     = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            rr_sum = {1'b0, rr_ptr} + (IDX_W+1)'(k);
            if (rr_sum >= NP_L) rr_sum = rr_sum - NP_L;
            if (!vld_p0 && eligible[rr_sum[IDX_W-1:0]]) begin
                vld_p0     = 1'b1;
                gnt_idx_p0 = rr_sum[IDX_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr <= '0;
        end else if (vld_p0) begin
            rr_ptr <= (gnt_idx_p0 == LAST_L) ? '0 : gnt_idx_p0 + 1'b1;
        end
    end
`else
    always_comb begin
        vld_p0     = 1'b0;
        gnt_idx_p0 = '0;
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            if (eligible[k]) begin
                vld_p0     = 1'b1;
                gnt_idx_p0 = IDX_W'(k);
            end
        end
    end
`endif

    assign we_p0    = port_we[gnt_idx_p0];
    assign addr_p0  = port_addr[gnt_idx_p0*ADDRESS_WIDTH +: ADDRESS_WIDTH];
    assign wdata_p0 = port_write_data[gnt_idx_p0*DATA_WIDTH +: DATA_WIDTH];

    generate
        if (MEMORY_DEPTH >= (2 ** ADDRESS_WIDTH)) begin : g_full_range
            assign in_range_p0 = 1'b1;
        end else begin : g_part_range
            localparam logic [ADDRESS_WIDTH:0] DEPTH_L = (ADDRESS_WIDTH+1)'(MEMORY_DEPTH);
            assign in_range_p0 = ({1'b0, addr_p0} < DEPTH_L);
        end
    endgenerate

    // p0 -> p1: granted access lands on the core / read register at the closing edge
    always_ff @(posedge clk) begin
        if (!reset && vld_p0 && we_p0 && in_range_p0) begin
            mem[addr_p0] <= wdata_p0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            port_done      <= '0;
            port_read_data <= '0;
        end else begin
            port_done <= '0;
            if (vld_p0) begin
                port_done[gnt_idx_p0] <= 1'b1;
                if (!we_p0) begin
                    port_read_data[gnt_idx_p0*DATA_WIDTH +: DATA_WIDTH] <= in_range_p0 ? mem[addr_p0] : '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_ram_nport_arb.sv
// Self-checking bench for ram_nport_arb: array-level reference model checked every cycle, plus directed cases.
// Follows RAM_NPORT_RR_ARB_EN to pick the arbitration rule the model applies.
`timescale 1ns/1ps
module tb_ram_nport_arb;
    localparam int NP = 4;
    localparam int AW = 10;
    localparam int DW = 32;
`ifdef RAM_NPORT_RR_ARB_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    logic [NP-1:0]    en, we, done;
    logic [NP*AW-1:0] addr;
    logic [NP*DW-1:0] wdata, rdata;

    logic [1:0]      d_en, d_we, d_done;
    logic [2*AW-1:0] d_addr;
    logic [2*DW-1:0] d_wdata, d_rdata;

    always #5 clk = ~clk;

    ram_nport_arb #(.NUM_PORTS(NP), .MEMORY_DEPTH(1024), .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .reset(reset), .port_en(en), .port_we(we), .port_addr(addr),
        .port_write_data(wdata), .port_read_data(rdata), .port_done(done));

    ram_nport_arb #(.NUM_PORTS(2), .MEMORY_DEPTH(1000), .DATA_WIDTH(DW)) dut_d (
        .clk(clk), .reset(reset), .port_en(d_en), .port_we(d_we), .port_addr(d_addr),
        .port_write_data(d_wdata), .port_read_data(d_rdata), .port_done(d_done));

    // reference model state
    logic [DW-1:0] m_mem [1024];
    logic [DW-1:0] m_rd [NP];
    logic [NP-1:0] m_done;
    int m_ptr;
    int checks = 0;
    int errors = 0;

    task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_port(int p, bit e, bit w, int a, logic [DW-1:0] d);
        en[p] = e;
        we[p] = w;
        addr[p*AW +: AW] = AW'(a);
        wdata[p*DW +: DW] = d;
    endtask

    task automatic model_step();
        int g;
        g = -1;
        if (reset) begin
            m_done = '0;
            m_ptr = 0;
            for (int i = 0; i < NP; i++) m_rd[i] = '0;
            return;
        end
        for (int k = 0; k < NP; k++) begin
            int p;
            p = RR ? (m_ptr + k) % NP : k;
            if (g < 0 && en[p] && !m_done[p]) g = p;
        end
        m_done = '0;
        if (g >= 0) begin
            m_done[g] = 1'b1;
            if (we[g]) m_mem[addr[g*AW +: AW]] = wdata[g*DW +: DW];
            else       m_rd[g] = m_mem[addr[g*AW +: AW]];
            if (RR) m_ptr = (g + 1) % NP;
        end
    endtask

    // one clock: advance the model on the inputs now applied, then compare after the edge
    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        checks++;
        if (done !== m_done) begin
            errors++;
            $display("FAIL done: got %b expected %b at %0t", done, m_done, $time);
        end
        for (int i = 0; i < NP; i++) begin
            checks++;
            if (rdata[i*DW +: DW] !== m_rd[i]) begin
                errors++;
                $display("FAIL rdata[%0d]: got %h expected %h at %0t", i, rdata[i*DW +: DW], m_rd[i], $time);
            end
        end
    endtask

    task automatic d_tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int p2cnt;
        reset = 1'b1;
        en = '0; we = '0; addr = '0; wdata = '0;
        d_en = '0; d_we = '0; d_addr = '0; d_wdata = '0;
        m_done = '0;
        m_ptr = 0;
        for (int i = 0; i < NP; i++) m_rd[i] = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_done", 128'(done), 128'h0);
        chk("reset_rdata", 128'(rdata), 128'h0);
        reset = 1'b0;

        // preload a small address window so every later read has a known value
        for (int a = 0; a < 16; a++) begin
            set_port(0, 1'b1, 1'b1, a, 32'hA5A5_0000 | 32'(a));
            cycle();
            en[0] = 1'b0;
            cycle();
        end

        // write then read the same address from another port
        set_port(0, 1'b1, 1'b1, 5, 32'hDEAD_BEEF);
        cycle();
        chk("w5_done", 128'(done), 128'h1);
        en[0] = 1'b0;
        set_port(1, 1'b1, 1'b0, 5, 32'h0);
        cycle();
        chk("r5_done", 128'(done), 128'h2);
        chk("r5_data", 128'(rdata[DW +: DW]), 128'hDEAD_BEEF);
        en[1] = 1'b0;
        cycle();

        // all four ports read at once from a freshly reset pointer
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        for (int p = 0; p < NP; p++) set_port(p, 1'b1, 1'b0, p, 32'h0);
        for (int s = 0; s < NP; s++) begin
            cycle();
            chk("all_rd_done", 128'(done), 128'(4'b0001 << s));
            chk("all_rd_data", 128'(rdata[s*DW +: DW]), 128'(32'hA5A5_0000 | 32'(s)));
            en[s] = 1'b0;
        end

        // same-cycle write (port2) and read (port3) of the top address
        set_port(2, 1'b1, 1'b1, 10'h3FF, 32'h1234_5678);
        set_port(3, 1'b1, 1'b0, 10'h3FF, 32'h0);
        cycle();
        chk("wr_first_done", 128'(done), 128'h4);
        en[2] = 1'b0;
        cycle();
        chk("rd_after_wr_done", 128'(done), 128'h8);
        chk("rd_after_wr_data", 128'(rdata[3*DW +: DW]), 128'h1234_5678);
        en[3] = 1'b0;
        cycle();

        // ports 0/1 re-request continuously while port2 waits
        set_port(0, 1'b1, 1'b0, 1, 32'h0);
        set_port(1, 1'b1, 1'b0, 2, 32'h0);
        set_port(2, 1'b1, 1'b0, 3, 32'h0);
        p2cnt = 0;
        repeat (100) begin
            cycle();
            if (done[2]) begin
                p2cnt++;
                en[2] = 1'b0;
            end
        end
        chk("port2_service_count", 128'(p2cnt), RR ? 128'd1 : 128'd0);
        en = '0;
        cycle();

        // reset mid-cycle with three requests pending and a write waiting on port3
        set_port(0, 1'b1, 1'b0, 1, 32'h0);
        set_port(1, 1'b1, 1'b0, 2, 32'h0);
        set_port(2, 1'b1, 1'b0, 3, 32'h0);
        cycle();
        reset = 1'b1;
        set_port(3, 1'b1, 1'b1, 7, 32'hBAD0_BAD0);
        #1;
        chk("midreset_done", 128'(done), 128'h0);
        chk("midreset_rdata", 128'(rdata), 128'h0);
        cycle();
        reset = 1'b0;
        en[3] = 1'b0;
        cycle();
        chk("post_reset_first_grant", 128'(done), 128'h1);
        en[0] = 1'b0;
        cycle();
        en[1] = 1'b0;
        cycle();
        en[2] = 1'b0;
        cycle();
        set_port(0, 1'b1, 1'b0, 7, 32'h0);
        cycle();
        chk("no_write_in_reset", 128'(rdata[DW-1:0]), 128'hA5A5_0007);
        en[0] = 1'b0;
        cycle();

        // randomized traffic; a port holds its request until done, then may re-request or drop
        for (int c = 0; c < 400; c++) begin
            for (int p = 0; p < NP; p++) begin
                if (en[p] && !m_done[p]) continue;
                if ((en[p] && m_done[p]) ? ($urandom % 2 == 0) : ($urandom % 3 == 0))
                    set_port(p, 1'b1, 1'($urandom % 2), int'($urandom % 16), $urandom);
                else
                    en[p] = 1'b0;
            end
            cycle();
        end
        en = '0;
        cycle();

        // out-of-range accesses on a 1000-word core
        d_en = 2'b01; d_we = 2'b01;
        d_addr[0 +: AW] = 10'd10; d_wdata[0 +: DW] = 32'h0000_0055;
        d_tick();
        chk("oor_prep_w_done", 128'(d_done), 128'h1);
        d_en = 2'b10; d_we = 2'b00; d_addr[AW +: AW] = 10'd10;
        d_tick();
        chk("oor_prep_r_done", 128'(d_done), 128'h2);
        chk("oor_prep_r_data", 128'(d_rdata[DW +: DW]), 128'h55);
        d_en = 2'b01; d_we = 2'b01;
        d_addr[0 +: AW] = 10'd1010; d_wdata[0 +: DW] = 32'h0000_FFFF;
        d_tick();
        chk("oor_w_done", 128'(d_done), 128'h1);
        d_en = 2'b10; d_we = 2'b00; d_addr[AW +: AW] = 10'd1010;
        d_tick();
        chk("oor_r_done", 128'(d_done), 128'h2);
        chk("oor_r_data", 128'(d_rdata[DW +: DW]), 128'h0);
        d_en = 2'b00;
        d_tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ram_nport_arb.md
RAM_NPORT_ARB -- requirements
Module: ram_nport_arb

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 4: number of requestor ports, legal range 2..16.
REQ-002 SHALL have parameter MEMORY_DEPTH, default 1024: number of words in the core.
REQ-003 SHALL have parameter ADDRESS_WIDTH, default $clog2(MEMORY_DEPTH): port address width.
REQ-004 SHALL have parameter DATA_WIDTH, default 32: word width.
REQ-005 SHALL have port clk  input  1  single clock; every register samples on its rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port port_en  input  NUM_PORTS  per-port go/request, held high until that port's done.
REQ-008 SHALL have port port_we  input  NUM_PORTS  per-port write select, qualified by port_en.
REQ-009 SHALL have port port_addr  input  NUM_PORTS*ADDRESS_WIDTH  packed addresses; port i occupies slice i.
REQ-010 SHALL have port port_write_data  input  NUM_PORTS*DATA_WIDTH  packed write data.
REQ-011 SHALL have port port_read_data  output  NUM_PORTS*DATA_WIDTH  packed, registered read data.
REQ-012 SHALL have port port_done  output  NUM_PORTS  per-port one-cycle completion pulse.

Function
REQ-013 SHALL implement one single-port core of MEMORY_DEPTH x DATA_WIDTH with exactly one access (read or write) per clk cycle.
REQ-014 SHALL treat port i as eligible in a cycle when port_en[i]=1 and port_done[i]=0.
REQ-015 SHALL grant, combinationally in cycle t, at most one eligible port; no eligible port means no core access.
REQ-016 SHALL perform the granted access at the clk edge closing cycle t: a write updates the core, a read loads port_read_data slice i.
REQ-017 SHALL assert port_done[i] for exactly cycle t+1; minimum latency from en to done is 1 cycle.
REQ-018 SHALL hold each port_read_data slice unchanged except on a granted read for that port; a granted write leaves it unchanged.
REQ-019 SHALL treat port_en[i] still high in cycle t+2 as a new request.
REQ-020 SHALL order accesses strictly by grant, so a read granted after a write to the same address returns the new data.
REQ-021 SHALL ignore writes to addresses >= MEMORY_DEPTH and return 0 on reads of them, each still completing with done.
REQ-022 SHALL leave a request's port_we, port_addr and port_write_data don't-care in any cycle in which that port is not granted.

Reset
REQ-023 SHALL, while reset=1 and independent of clk, drive port_done to all 0 and port_read_data to all 0.
REQ-024 SHALL, while reset=1 and independent of clk, set the round-robin pointer to 0.
REQ-025 SHALL not initialise core contents on reset.
REQ-026 SHALL drop any request pending when reset asserts; after release, requests held high are arbitrated afresh.
REQ-027 SHALL perform no core write in any cycle in which reset=1.

Configuration
REQ-028 SHALL, with macro RAM_NPORT_RR_ARB_EN defined, use round-robin arbitration: search starts at the pointer, and after a grant to port i the pointer becomes (i+1) mod NUM_PORTS.
REQ-029 SHALL, with RAM_NPORT_RR_ARB_EN undefined, use fixed priority: the lowest-index eligible port wins, the pointer logic is absent, and starvation is permitted.

Verification
REQ-030 SHALL cover: port0 writes addr 5 = 0xDEADBEEF, then port1 reads addr 5 -> port1 done after 1 cycle, port1 read data = 0xDEADBEEF.
REQ-031 SHALL cover, with RR_ARB_EN and all 4 ports reading in the same cycle: done pulses in cycles 1, 2, 3, 4 for ports 0, 1, 2, 3, and the pointer returns to 0.
REQ-032 SHALL cover, with RR_ARB_EN and pointer=0: port2 writes addr 0x3FF = 0x12345678 while port3 reads 0x3FF in the same cycle -> port2 done first, port3 reads 0x12345678.
REQ-033 SHALL cover, without the macro: ports 0 and 1 re-request continuously and port2 requests -> port2 never receives done over 100 cycles.
REQ-034 SHALL cover: reset asserted mid-cycle with 3 requests pending -> port_done and port_read_data go to 0 before the next edge; after release, the first grant goes to port0.
REQ-035 SHALL cover, with MEMORY_DEPTH=1000: write addr 1010 = 0xFFFF, then read addr 1010 -> both complete with done, and the read data = 0.
